mux16_rr_arbiter: RTL and testbench
===================================

// Module: mux16_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one N-bit 16:1 mux (mux16) among 16 requesters.
//  Selects one requesting source, drives the mux select, and captures the selected word
//  into an output register. Presents that word downstream with a valid/ready handshake.
//  Sits between 16 producer lanes and a single shared consumer; a mask input gates lanes.
// PARAMETERS
//  N  1  data width per lane (passed to the mux16 instance)
// PORTS
//  clk        in   1     system clock, all state on rising edge
//  rst_n      in   1     asynchronous, active-low reset
//  req        in   16    req[i]=1: lane i has a valid word on in_data slice i
//  in_data    in   16*N  lane i word = in_data[i*N +: N]
//  ack        out  16    ack[i]=1: lane i word is consumed at this clock edge (one-hot or 0)
//  mask       in   16    mask[i]=1 enables lane i; masked lanes never win
//  out_valid  out  1     output register holds a word
//  out_ready  in   1     downstream accepts the word when out_valid & out_ready
//  out_data   out  N     captured word
//  out_src    out  4     lane index out_data came from
//  busy       out  1     1 when state is HOLD (same as out_valid)
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, out_valid=0, out_data=0, out_src=0, ptr=0.
//    ack=0 while rst_n=0. Reset mid-HOLD drops the held word with no ack and no handshake.
//  Eligible vector: elig = req & mask.
//  Winner: first set bit of elig scanning ptr, ptr+1, ... 15, 0, ... ptr-1 (mod 16).
//    ptr is 4 bits and wraps 15->0.
//  Internal select = winner. It drives a mux16 instance whose output feeds the out_data
//    register D input.
//  load = (|elig) & (state==IDLE | (out_valid & out_ready)).
//  ack[i] = load & (winner==i). ack is combinational from req, mask, state and out_ready.
//    The lane must hold in_data stable while req=1 and ack=0.
//  On load: out_data <= mux16 output; out_src <= winner; out_valid <= 1;
//    ptr <= winner+1 (mod 16); state <= HOLD.
//  FSM IDLE: out_valid=0.
//    |elig -> load, go to HOLD.
//    Otherwise stay in IDLE.
//  FSM HOLD: out_valid=1. out_data and out_src are stable until the handshake.
//    out_ready=0 -> hold every output. Changes on req, mask or in_data have no effect; ack=0.
//    out_ready=1 and |elig -> back-to-back load in the same cycle; stay in HOLD.
//    out_ready=1 and no eligible lane -> out_valid <= 0; go to IDLE.
//  Latency: req at edge t in IDLE -> out_valid=1 after edge t+1 (1 cycle).
//    Sustained throughput is 1 word/cycle when out_ready=1.
//  Fairness: a continuously eligible lane wins within 16 loads; the last winner has lowest
//    priority on the next arbitration.
//  Mask cleared on a lane while that lane is held: the held word is still delivered.
//  Lane with req=1, mask=0: never acked; the lane waits indefinitely.
//  A win with req deasserted in the same cycle cannot occur: ack requires req.
// TESTING
//  1 Reset: rst_n=0 mid-HOLD with out_valid=1 -> out_valid, out_data, out_src and ack go to 0
//    immediately, without waiting for clk; after release, first winner is the lowest eligible lane.
//  2 Single lane: mask=FFFF, req=0x0020, data5=0xA, out_ready=1 -> ack[5] for 1 cycle.
//    Next cycle: out_valid=1, out_data=0xA, out_src=5. Then idle; out_valid=0 after handshake.
//  3 All lanes: req=FFFF, mask=FFFF, out_ready=1 -> out_src sequence 0,1,...,15,0,1.
//    One ack per cycle, no gaps.
//  4 Backpressure: HOLD with out_src=3 and out_ready=0 for 5 cycles while req and data change
//    -> out_data and out_src constant, ack=0. out_ready=1 -> next lane after 3 is loaded.
//  5 Wrap and mask: ptr=15, req=0x8009, mask=0x0008 -> winner=3 (lanes 0 and 15 masked).
//    ptr becomes 4.
//  6 Starvation: lanes 2 and 9 held requesting, out_ready toggling randomly
//    -> grants strictly alternate 2,9,2,9.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter that shares one N-bit 16:1 mux among
// 16 producer lanes and registers the selected word for a single consumer.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   req[16]    lane i offers a word on in_data[i*N +: N]
//   in_data    16 packed lane words
//   mask[16]   lane enable; masked lanes never win
//   ack[16]    one-hot (or 0): lane word consumed at this clock edge
//   out_valid  output register holds a word
//   out_ready  downstream accepts when out_valid & out_ready
//   out_data   captured word
//   out_src    lane index of out_data
//   busy       state is HOLD (same as out_valid)

// Plain 16:1 word mux; select picks lane word sel.
module mux16 #(
  parameter int N = 1
) (
  input  logic [3:0]      sel,
  input  logic [16*N-1:0] din,
  output logic [N-1:0]    dout
);
  assign dout = din[sel*N +: N];
endmodule

// Per-lane qualify/grant slice.
module rr_lane #(
  parameter logic [3:0] LANE = 4'd0
) (
  input  logic       req,
  input  logic       mask,
  input  logic       load,
  input  logic [3:0] winner,
  output logic       elig,
  output logic       ack
);
  assign elig = req & mask;
  // winner is only meaningful when some lane is eligible, and load already
  // implies that, so no extra qualification is needed here.
  assign ack  = load & (winner == LANE);
endmodule

module mux16_rr_arbiter #(
  parameter int N = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     req,
  input  logic [16*N-1:0] in_data,
  output logic [15:0]     ack,
  input  logic [15:0]     mask,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    out_data,
  output logic [3:0]      out_src,
  output logic            busy
);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ptr;
  logic [15:0] elig;
  logic [15:0] lane_ack;
  logic [15:0] rot;
  logic [3:0]  off;
  logic [3:0]  winner;
  logic        any_elig;
  logic        load;
  logic [N-1:0] mux_out;

  // Per-lane qualification and grant decode.
  for (genvar i = 0; i < 16; i++) begin : g_lane
    rr_lane #(.LANE(4'(i))) u_lane (
      .req    (req[i]),
      .mask   (mask[i]),
      .load   (load),
      .winner (winner),
      .elig   (elig[i]),
      .ack    (lane_ack[i])
    );
  end

  // Rotate elig so bit 0 is the lane at ptr; the lowest set bit of the
  // rotated vector is the offset of the winner from ptr. 4-bit adds wrap
  // naturally, giving the mod-16 scan order ptr, ptr+1, ..., ptr-1.
  always_comb begin
    rot = '0;
    for (int k = 0; k < 16; k++) rot[k] = elig[ptr + 4'(k)];
  end

  always_comb begin
    off = '0;
    for (int k = 15; k >= 0; k--) if (rot[k]) off = 4'(k);
  end

  assign winner   = ptr + off;
  assign any_elig = |elig;

  // A new word may enter when the register is empty or is being drained
  // this same edge, giving one word per cycle under sustained ready.
  assign load = any_elig & ((state == IDLE) | (out_valid & out_ready));

  // Gate with rst_n: in reset the FSM reads IDLE, which would otherwise let
  // load (and so ack) rise combinationally from req.
  assign ack = lane_ack & {16{rst_n}};

  mux16 #(.N(N)) u_mux (
    .sel  (winner),
    .din  (in_data),
    .dout (mux_out)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (any_elig) state_nxt = HOLD;
      HOLD: if (out_ready && !any_elig) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    out_valid = (state == HOLD);
    busy      = (state == HOLD);
  end

  // Datapath registers: captured word, its source lane and the RR pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_src  <= '0;
      ptr      <= '0;
    end else if (load) begin
      out_data <= mux_out;
      out_src  <= winner;
      ptr      <= winner + 4'd1;  // last winner drops to lowest priority
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed bench for mux16_rr_arbiter with N=4. Inputs change on the falling
// edge; ack is checked 1 time unit later, registered outputs after the next
// falling edge.
module tb_mux16_rr_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   req, mask, ack;
  logic [16*N-1:0] in_data;
  logic          out_valid, out_ready, busy;
  logic [N-1:0]  out_data;
  logic [3:0]    out_src;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .in_data   (in_data),
    .ack       (ack),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Lane i word = i, so out_data must equal out_src after every load.
  task automatic idx_data();
    for (int i = 0; i < 16; i++) in_data[i*N +: N] = N'(i);
  endtask

  initial begin
    int exp_src;
    rst_n = 1'b0; req = '0; mask = 16'hFFFF; out_ready = 1'b0;
    idx_data();
    @(negedge clk);
    req = 16'hFFFF;
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ack",   32'(ack), 0);
    chk("rst_src",   32'(out_src), 0);
    chk("rst_busy",  32'(busy), 0);
    @(negedge clk);
    req = '0; rst_n = 1'b1;

    // Single lane
    tick();
    in_data[5*N +: N] = 4'hA;
    req = 16'h0020; out_ready = 1'b1;
    #1 chk("single_ack", 32'(ack), 32'h0020);
    tick();
    req = '0;
    #1;
    chk("single_valid", 32'(out_valid), 1);
    chk("single_data",  32'(out_data), 32'hA);
    chk("single_src",   32'(out_src), 5);
    chk("single_ack0",  32'(ack), 0);
    tick();
    chk("single_idle", 32'(out_valid), 0);

    // Reset mid-HOLD, asynchronous
    idx_data();
    req = 16'h0100; out_ready = 1'b0;
    tick();
    chk("hold_valid", 32'(out_valid), 1);
    chk("hold_src",   32'(out_src), 8);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_data",  32'(out_data), 0);
    chk("arst_src",   32'(out_src), 0);
    chk("arst_ack",   32'(ack), 0);
    @(negedge clk);
    rst_n = 1'b1; req = 16'h0300;
    #1 chk("post_rst_ack", 32'(ack), 32'h0100);
    tick();
    chk("post_rst_src", 32'(out_src), 8);
    req = '0; out_ready = 1'b1;
    tick();

    // Clean reset so the pointer is back at 0
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // All lanes, back-to-back
    req = 16'hFFFF; mask = 16'hFFFF; out_ready = 1'b1;
    for (int k = 0; k < 18; k++) begin
      #1 chk($sformatf("all_ack%0d", k), 32'(ack), 32'(16'h1 << (k % 16)));
      tick();
      chk($sformatf("all_src%0d", k), 32'(out_src), 32'(k % 16));
      chk($sformatf("all_data%0d", k), 32'(out_data), 32'(k % 16));
    end
    // ptr = 2 now; load lane 3 then stall
    req = 16'h0008;
    tick();
    chk("bp_src_load", 32'(out_src), 3);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      req = 16'($urandom) | 16'h0001;
      in_data = {$urandom, $urandom};
      #1 chk($sformatf("bp_ack%0d", k), 32'(ack), 0);
      tick();
      chk($sformatf("bp_src%0d", k), 32'(out_src), 3);
      chk($sformatf("bp_data%0d", k), 32'(out_data), 3);
      chk($sformatf("bp_valid%0d", k), 32'(out_valid), 1);
    end
    idx_data();
    req = 16'hFFFF; out_ready = 1'b1;
    #1 chk("bp_release_ack", 32'(ack), 32'h0010);
    tick();
    chk("bp_release_src", 32'(out_src), 4);

    // Wrap and mask: bring ptr to 15, then lanes 0 and 15 masked off
    req = 16'h4000;
    tick();
    chk("wrap_pre_src", 32'(out_src), 14);
    req = 16'h8009; mask = 16'h0008;
    #1 chk("wrap_ack", 32'(ack), 32'h0008);
    tick();
    chk("wrap_src", 32'(out_src), 3);
    req = 16'h0018; mask = 16'hFFFF;
    #1 chk("wrap_ptr4_ack", 32'(ack), 32'h0010);
    tick();
    chk("wrap_ptr4_src", 32'(out_src), 4);

    // Masked requester is never acked
    req = 16'h0040; mask = 16'hFFBF;
    for (int k = 0; k < 3; k++) begin
      #1 chk($sformatf("masked_ack%0d", k), 32'(ack), 0);
      tick();
    end
    chk("masked_idle", 32'(out_valid), 0);

    // Starvation: lanes 2 and 9 with random backpressure; ptr = 5 so 9 first
    mask = 16'hFFFF; req = 16'h0204;
    exp_src = 9;
    for (int k = 0; k < 24; k++) begin
      logic held;
      int   prev;
      held = out_valid;
      prev = int'(out_src);
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (!held || out_ready) begin
        chk($sformatf("starve_ack%0d", k), 32'(ack), 32'(16'h1 << exp_src));
        tick();
        chk($sformatf("starve_src%0d", k), 32'(out_src), 32'(exp_src));
        exp_src = (exp_src == 9) ? 2 : 9;
      end else begin
        chk($sformatf("starve_hold_ack%0d", k), 32'(ack), 0);
        tick();
        chk($sformatf("starve_hold_src%0d", k), 32'(out_src), 32'(prev));
      end
    end

    req = '0; out_ready = 1'b1;
    tick();
    chk("final_idle", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
